// File: rtl/timer_sequencer.sv
// Sequences bus writes to a memory-mapped interval timer (start, stop, irq service, snapshot).
// Define TIMER_SEQUENCER_SNAPSHOT_EN to enable the counter snapshot read-back path.
module timer_sequencer #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h017D783F,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_period,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             snap_valid,
  output logic [31:0]      snap_value,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq
);

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    CLR_STS,
    GUARD,
    WR_STOP,
    SNAP_WR,
    SNAP_RL,
    SNAP_RH,
    SNAP_DONE
  } state_t;

  localparam logic [1:0] OP_START_PERIODIC = 2'd0;
  localparam logic [1:0] OP_START_ONESHOT  = 2'd1;
  localparam logic [1:0] OP_STOP           = 2'd2;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam logic [15:0] CTRL_PERIODIC = 16'h0007;
  localparam logic [15:0] CTRL_ONESHOT  = 16'h0005;
  localparam logic [15:0] CTRL_STOP     = 16'h0008;

  state_t           state_q, state_d;
  logic             oneshot_q, oneshot_d;
  logic [31:0]      period_q, period_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic             rdy_en_q, rdy_en_d;
  logic             cmd_fire;

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;
  logic        ret_run_q, ret_run_d;
`else
  logic        unused_rd;
  assign unused_rd = ^tmr_readdata;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      oneshot_q    <= 1'b0;
      period_q     <= '0;
      tick_count_q <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      oneshot_q    <= oneshot_d;
      period_q     <= period_d;
      tick_count_q <= tick_count_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

  // Holding ready low for the first cycle out of reset keeps a command from racing the reset release.
  assign rdy_en_d = 1'b1;

  always_comb begin
    cmd_ready = 1'b0;
    if (rdy_en_q) begin
      if (state_q == IDLE) begin
        cmd_ready = 1'b1;
      end else if (state_q == RUN && !tmr_irq) begin
        cmd_ready = 1'b1;
      end
    end
  end

  assign cmd_fire = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    oneshot_d    = oneshot_q;
    period_d     = period_q;
    tick_count_d = tick_count_q;
    case (state_q)
      IDLE, RUN: begin
        // A pending interrupt in RUN always wins over a new command.
        if (state_q == RUN && tmr_irq) begin
          state_d      = CLR_STS;
          tick_count_d = tick_count_q + CNT_W'(1);
        end else if (cmd_fire) begin
          case (cmd_op)
            OP_START_PERIODIC, OP_START_ONESHOT: begin
              state_d      = WR_PL;
              oneshot_d    = (cmd_op == OP_START_ONESHOT);
              period_d     = (cmd_period == 32'd0) ? DEFAULT_PERIOD : cmd_period;
              tick_count_d = '0;
            end
            OP_STOP: begin
              state_d = WR_STOP;
            end
            default: begin
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
              state_d = SNAP_WR;
`else
              state_d = state_q;
`endif
            end
          endcase
        end
      end
      WR_PL:     state_d = WR_PH;
      WR_PH:     state_d = WR_CTRL;
      WR_CTRL:   state_d = RUN;
      CLR_STS:   state_d = GUARD;
      GUARD:     state_d = oneshot_q ? IDLE : RUN;
      WR_STOP:   state_d = IDLE;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      SNAP_WR:   state_d = SNAP_RL;
      SNAP_RL:   state_d = SNAP_RH;
      SNAP_RH:   state_d = SNAP_DONE;
      SNAP_DONE: state_d = ret_run_q ? RUN : IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_address    = '0;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_writedata  = '0;
    case (state_q)
      WR_PL: begin
        tmr_address    = ADDR_PERIODL;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_writedata  = period_q[15:0];
      end
      WR_PH: begin
        tmr_address    = ADDR_PERIODH;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_writedata  = period_q[31:16];
      end
      WR_CTRL: begin
        tmr_address    = ADDR_CONTROL;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_writedata  = oneshot_q ? CTRL_ONESHOT : CTRL_PERIODIC;
      end
      CLR_STS: begin
        tmr_address    = ADDR_STATUS;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
      end
      WR_STOP: begin
        tmr_address    = ADDR_CONTROL;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_writedata  = CTRL_STOP;
      end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      SNAP_WR: begin
        tmr_address    = ADDR_SNAPL;
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
      end
      SNAP_RL: tmr_address = ADDR_SNAPL;
      SNAP_RH: tmr_address = ADDR_SNAPH;
`endif
      default: ;
    endcase
  end

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snap_q    <= '0;
      ret_run_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      ret_run_q <= ret_run_d;
    end
  end

  // Read data trails the presented address by one cycle, so each half lands one state later.
  always_comb begin
    snap_d    = snap_q;
    ret_run_d = ret_run_q;
    if (cmd_fire && state_q != SNAP_WR) begin
      ret_run_d = (state_q == RUN);
    end
    if (state_q == SNAP_RH) begin
      snap_d[15:0] = tmr_readdata;
    end
    if (state_q == SNAP_DONE) begin
      snap_d[31:16] = tmr_readdata;
    end
  end

  assign snap_valid = (state_q == SNAP_DONE);
  assign snap_value = (state_q == SNAP_DONE) ? {tmr_readdata, snap_q[15:0]} : snap_q;
`else
  assign snap_valid = 1'b0;
  assign snap_value = '0;
`endif

  assign busy       = (state_q != IDLE);
  assign tick       = (state_q == CLR_STS);
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: spec vectors, corner sequences and a randomized
// transaction-level model; a second CNT_W=4 instance shares all stimulus to cover counter wrap.
module tb_timer_sequencer;

  localparam logic [31:0] DEF_PERIOD = 32'h017D783F;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, tmr_irq;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic [15:0] tmr_readdata = '0;

  logic        cmd_ready, busy, tick, snap_valid, tmr_chipselect, tmr_write_n;
  logic [15:0] tick_count, tmr_writedata;
  logic [31:0] snap_value;
  logic [2:0]  tmr_address;

  logic        u4_ready_unused, u4_busy_unused, u4_tick_unused, u4_sv_unused, u4_cs_unused, u4_wn_unused;
  logic [3:0]  tick_count4;
  logic [31:0] u4_snap_unused;
  logic [2:0]  u4_addr_unused;
  logic [15:0] u4_wdata_unused;

  always #5 clk = ~clk;

  timer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .busy(busy), .tick(tick),
    .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  timer_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(u4_ready_unused),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .busy(u4_busy_unused), .tick(u4_tick_unused),
    .tick_count(tick_count4), .snap_valid(u4_sv_unused), .snap_value(u4_snap_unused),
    .tmr_address(u4_addr_unused), .tmr_chipselect(u4_cs_unused), .tmr_write_n(u4_wn_unused),
    .tmr_writedata(u4_wdata_unused), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // Timer slave model: registered read data for the snapshot registers
  always @(posedge clk) begin
    case (tmr_address)
      3'd4:    tmr_readdata <= 16'h1234;
      3'd5:    tmr_readdata <= 16'h00AB;
      default: tmr_readdata <= 16'h0000;
    endcase
  end

  typedef struct packed { logic [2:0] addr; logic [15:0] data; } wr_t;
  wr_t act_q[$];
  wr_t exp_q[$];
  int  act_rd = 0;
  int  proto_errs = 0;
  bit  mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (tmr_chipselect && !tmr_write_n) act_q.push_back({tmr_address, tmr_writedata});
      if (tmr_chipselect === tmr_write_n) proto_errs++;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          model_count = 0;
  bit          model_run = 0;
  bit          model_oneshot = 0;
  logic [31:0] model_snap = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] period;
    logic [15:0] pl;
    logic [15:0] ph;
    logic [15:0] ctrl;
  } vec_t;
  vec_t vecs[5];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] per, input logic irq);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_period = per;
    tmr_irq    = irq;
  endtask

  task automatic checkBus(input string name, input logic cs, input logic [2:0] addr, input logic [15:0] data);
    checkOutput({name, "_cs"}, tmr_chipselect, cs);
    checkOutput({name, "_wn"}, tmr_write_n, !cs);
    checkOutput({name, "_addr"}, tmr_address, addr);
    checkOutput({name, "_data"}, tmr_writedata, data);
  endtask

  task automatic checkCount(input string name);
    checkOutput(name, tick_count, model_count % 65536);
    checkOutput({name, "_w4"}, tick_count4, model_count % 16);
  endtask

  task automatic compareWrites(input string name);
    bit bad = 0;
    int n = act_q.size() - act_rd;
    checks++;
    if (n != exp_q.size()) begin
      bad = 1;
      $display("[TB] FAIL %s: actual=%0d writes required=%0d writes", name, n, exp_q.size());
    end else begin
      for (int i = 0; i < n; i++) begin
        if (!bad && act_q[act_rd + i] !== exp_q[i]) begin
          bad = 1;
          $display("[TB] FAIL %s[%0d]: actual=(%0d,%h) required=(%0d,%h)", name, i,
                   act_q[act_rd + i].addr, act_q[act_rd + i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    if (bad) failures++;
    act_rd = act_q.size();
    exp_q.delete();
    checkOutput({name, "_protocol"}, proto_errs, 0);
  endtask

  task automatic sendCmd(input logic [1:0] op, input logic [31:0] per);
    bit done = 0;
    applyStimulus(1'b1, op, per, tmr_irq);
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (cmd_ready) done = 1;
      cyc();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL accept_timeout: actual=no handshake required=handshake");
    end
  endtask

  task automatic waitReady(input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (cmd_ready) ok = 1;
      else cyc();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s_timeout: actual=ready low required=ready high", name);
    end
  endtask

  task automatic modelStart(input logic [1:0] op, input logic [31:0] per);
    logic [31:0] p;
    p = (per == 32'd0) ? DEF_PERIOD : per;
    model_count   = 0;
    model_run     = 1;
    model_oneshot = (op == 2'd1);
    exp_q.push_back({3'd2, p[15:0]});
    exp_q.push_back({3'd3, p[31:16]});
    exp_q.push_back({3'd1, model_oneshot ? 16'h0005 : 16'h0007});
  endtask

  task automatic runStart(input logic [1:0] op, input logic [31:0] per);
    sendCmd(op, per);
    modelStart(op, per);
    cyc();
    cyc();
    cyc();
    checkOutput("start_busy", busy, 1);
    checkOutput("start_ready", cmd_ready, 1);
    checkCount("start_count");
  endtask

  task automatic serviceIrq();
    tmr_irq = 1'b1;
    #1;
    checkOutput("irq_holds_ready", cmd_ready, 0);
    cyc();
    model_count++;
    exp_q.push_back({3'd0, 16'h0000});
    checkOutput("svc_tick", tick, 1);
    checkBus("svc_clr", 1'b1, 3'd0, 16'h0000);
    checkCount("svc_count");
    cyc();
    tmr_irq = 1'b0;
    checkOutput("guard_tick", tick, 0);
    checkOutput("guard_cs", tmr_chipselect, 0);
    checkOutput("guard_busy", busy, 1);
    cyc();
    if (model_oneshot) model_run = 0;
    checkOutput("svc_busy_after", busy, model_run);
    checkOutput("svc_ready_after", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned r;
    logic [31:0] per;
    bit          seen;

    vecs[0] = '{2'd0, 32'h0001_86A0, 16'h86A0, 16'h0001, 16'h0007};
    vecs[1] = '{2'd1, 32'h0000_0000, 16'h783F, 16'h017D, 16'h0005};
    vecs[2] = '{2'd0, 32'h0000_0000, 16'h783F, 16'h017D, 16'h0007};
    vecs[3] = '{2'd1, 32'hDEAD_BEEF, 16'hBEEF, 16'hDEAD, 16'h0005};
    vecs[4] = '{2'd0, 32'h0000_0001, 16'h0001, 16'h0000, 16'h0007};

    reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0);
    cyc();
    cyc();
    checkOutput("rst_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tick", tick, 0);
    checkCount("rst_count");
    checkOutput("rst_snap_valid", snap_valid, 0);
    checkOutput("rst_snap_value", snap_value, 0);
    checkBus("rst_bus", 1'b0, 3'd0, 16'h0000);
    mon_en  = 1;
    reset_n = 1'b1;
    #1;
    checkOutput("ready_before_release", cmd_ready, 0);
    cyc();
    checkOutput("ready_after_release", cmd_ready, 1);

    $display("[TB] irq while idle");
    tmr_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checkOutput("idle_irq_tick", tick, 0);
      checkOutput("idle_irq_busy", busy, 0);
      checkOutput("idle_irq_ready", cmd_ready, 1);
    end
    tmr_irq = 1'b0;
    checkCount("idle_irq_count");
    compareWrites("idle_irq_writes");

    $display("[TB] start vectors");
    for (int v = 0; v < 5; v++) begin
      sendCmd(vecs[v].op, vecs[v].period);
      modelStart(vecs[v].op, vecs[v].period);
      checkBus($sformatf("vec%0d_pl", v), 1'b1, 3'd2, vecs[v].pl);
      checkOutput($sformatf("vec%0d_busy", v), busy, 1);
      checkOutput($sformatf("vec%0d_ready_low", v), cmd_ready, 0);
      cyc();
      checkBus($sformatf("vec%0d_ph", v), 1'b1, 3'd3, vecs[v].ph);
      cyc();
      checkBus($sformatf("vec%0d_ctrl", v), 1'b1, 3'd1, vecs[v].ctrl);
      cyc();
      checkBus($sformatf("vec%0d_run", v), 1'b0, 3'd0, 16'h0000);
      checkOutput($sformatf("vec%0d_run_busy", v), busy, 1);
      checkOutput($sformatf("vec%0d_run_ready", v), cmd_ready, 1);
      checkCount($sformatf("vec%0d_count", v));
      compareWrites($sformatf("vec%0d_writes", v));
      serviceIrq();
      compareWrites($sformatf("vec%0d_svc_writes", v));
    end

    $display("[TB] periodic three services");
    runStart(2'd0, 32'h0001_86A0);
    for (int i = 0; i < 3; i++) serviceIrq();
    checkOutput("p3_count", tick_count, 3);
    checkOutput("p3_busy", busy, 1);
    compareWrites("p3_writes");

    $display("[TB] snapshot from run");
    sendCmd(2'd3, 32'd0);
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    exp_q.push_back({3'd4, 16'h0000});
    checkBus("snap_wr", 1'b1, 3'd4, 16'h0000);
    checkOutput("snap_wr_busy", busy, 1);
    cyc();
    checkBus("snap_rl", 1'b0, 3'd4, 16'h0000);
    cyc();
    checkBus("snap_rh", 1'b0, 3'd5, 16'h0000);
    checkOutput("snap_rh_valid", snap_valid, 0);
    cyc();
    checkOutput("snap_done_valid", snap_valid, 1);
    checkOutput("snap_done_value", snap_value, 32'h00AB1234);
    cyc();
    model_snap = 32'h00AB1234;
    checkOutput("snap_after_valid", snap_valid, 0);
    checkOutput("snap_after_value", snap_value, 32'h00AB1234);
    checkOutput("snap_after_busy", busy, 1);
    checkOutput("snap_after_ready", cmd_ready, 1);
`else
    checkBus("snap_nop", 1'b0, 3'd0, 16'h0000);
    checkOutput("snap_nop_busy", busy, 1);
    checkOutput("snap_nop_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("snap_nop_valid", snap_valid, 0);
      checkOutput("snap_nop_value", snap_value, 0);
      cyc();
    end
`endif
    compareWrites("snap_writes");

    $display("[TB] irq and stop together");
    applyStimulus(1'b1, 2'd2, 32'd0, 1'b1);
    #1;
    checkOutput("irqstop_ready", cmd_ready, 0);
    cyc();
    model_count++;
    exp_q.push_back({3'd0, 16'h0000});
    checkBus("irqstop_clr", 1'b1, 3'd0, 16'h0000);
    checkOutput("irqstop_tick", tick, 1);
    cyc();
    tmr_irq = 1'b0;
    checkOutput("irqstop_guard_ready", cmd_ready, 0);
    cyc();
    #1;
    checkOutput("irqstop_run_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    exp_q.push_back({3'd1, 16'h0008});
    checkBus("irqstop_stop", 1'b1, 3'd1, 16'h0008);
    cyc();
    model_run = 0;
    checkOutput("irqstop_busy", busy, 0);
    checkCount("irqstop_count");
    compareWrites("irqstop_writes");

    $display("[TB] stop from idle");
    sendCmd(2'd2, 32'd0);
    exp_q.push_back({3'd1, 16'h0008});
    checkBus("idle_stop", 1'b1, 3'd1, 16'h0008);
    cyc();
    checkOutput("idle_stop_busy", busy, 0);
    checkOutput("idle_stop_ready", cmd_ready, 1);
    checkCount("idle_stop_count");
    compareWrites("idle_stop_writes");

    $display("[TB] counter wrap");
    runStart(2'd0, 32'h0000_0010);
    for (int i = 0; i < 16; i++) serviceIrq();
    checkOutput("wrap_w4", tick_count4, 0);
    checkOutput("wrap_main", tick_count, 16);
    compareWrites("wrap_writes");

    $display("[TB] reset during period-high write");
    sendCmd(2'd0, 32'h0002_0003);
    checkBus("rst_mid_pl", 1'b1, 3'd2, 16'h0003);
    cyc();
    checkBus("rst_mid_ph", 1'b1, 3'd3, 16'h0002);
    reset_n = 1'b0;
    exp_q.push_back({3'd2, 16'h0003});
    exp_q.push_back({3'd3, 16'h0002});
    cyc();
    model_count = 0;
    model_run   = 0;
    model_snap  = '0;
    checkBus("rst_mid_bus", 1'b0, 3'd0, 16'h0000);
    checkCount("rst_mid_count");
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_ready", cmd_ready, 0);
    checkOutput("rst_mid_snap", snap_value, 0);
    reset_n = 1'b1;
    cyc();
    checkOutput("rst_mid_ready_up", cmd_ready, 1);
    cyc();
    checkOutput("rst_mid_idle_busy", busy, 0);
    compareWrites("rst_mid_writes");

    $display("[TB] randomized transactions");
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1: begin
          per = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
          sendCmd(r[1:0], per);
          modelStart(r[1:0], per);
          waitReady("rand_start");
        end
        2: begin
          sendCmd(2'd2, 32'd0);
          exp_q.push_back({3'd1, 16'h0008});
          model_run = 0;
          waitReady("rand_stop");
        end
        3: begin
          sendCmd(2'd3, 32'd0);
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
          exp_q.push_back({3'd4, 16'h0000});
          model_snap = 32'h00AB1234;
`endif
          waitReady("rand_snap");
        end
        default: begin
          if (model_run) begin
            tmr_irq = 1'b1;
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
              cyc();
              if (tick) seen = 1;
            end
            tmr_irq = 1'b0;
            checks++;
            if (!seen) begin
              failures++;
              $display("[TB] FAIL rand_tick_timeout: actual=no tick required=tick");
            end
            model_count++;
            exp_q.push_back({3'd0, 16'h0000});
            if (model_oneshot) model_run = 0;
            waitReady("rand_irq");
          end else begin
            tmr_irq = 1'b1;
            for (int i = 0; i < 3; i++) begin
              cyc();
              checkOutput("rand_idle_irq_tick", tick, 0);
            end
            tmr_irq = 1'b0;
          end
        end
      endcase
      compareWrites("rand_writes");
      checkOutput("rand_busy", busy, model_run);
      checkCount("rand_count");
      checkOutput("rand_snap_value", snap_value, model_snap);
      checkOutput("rand_snap_valid", snap_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
